// File: rtl/hpp_pkg.sv
// Shared constants and fetch-engine state encoding for the HPP grid fetcher.
package hpp_pkg;

   localparam int GRID_W       = 80;   // cells per row
   localparam int GRID_H       = 60;   // cell rows
   localparam int CELL_SHIFT   = 3;    // log2 of cell edge in pixels
   localparam int ADDR_W       = 13;   // grid RAM address width
   localparam int CELL_BITS    = 5;    // {obstacle,a,b,c,d}
   localparam int OBSTACLE_BIT = 4;
   localparam int COL_W        = $clog2(GRID_W);
   localparam int ROW_W        = $clog2(GRID_H);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FILL  = 2'd1,
      DRAIN = 2'd2
   } fetch_state_e;

endpackage

// File: rtl/hpp_line_buffer.sv
// Two-bank cell-row buffer: one write port for the fetch engine, one
// combinational read port for the pixel lookup. Valid bits live in the parent.
module hpp_line_buffer
   import hpp_pkg::*;
(
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 wr_en,
   input  logic                 wr_bank,
   input  logic [COL_W-1:0]     wr_col,
   input  logic [CELL_BITS-1:0] wr_data,
   input  logic                 rd_bank,
   input  logic [COL_W-1:0]     rd_col,
   output logic [CELL_BITS-1:0] rd_data
);

   localparam logic [COL_W:0] DEPTH = (COL_W + 1)'(GRID_W);

   logic [CELL_BITS-1:0] mem_q [2][GRID_W];

   // Cell storage: cleared on reset, written one cell per accepted read.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int b = 0; b < 2; b++) begin
            for (int c = 0; c < GRID_W; c++) begin
               mem_q[b][c] <= '0;
            end
         end
      end else if (wr_en && ({1'b0, wr_col} < DEPTH)) begin
         mem_q[wr_bank][wr_col] <= wr_data;
      end
   end

   // Column indices past the row end read as zero instead of indexing off the array.
   always_comb begin
      rd_data = '0;
      if ({1'b0, rd_col} < DEPTH) begin
         rd_data = mem_q[rd_bank][rd_col];
      end
   end

endmodule

// File: rtl/hpp_grid_fetcher.sv
// Prefetches grid cell rows into a ping-pong line buffer ahead of the VGA
// raster and answers pixel lookups combinationally.
// Optional build macro: HPP_FETCH_OOB_OBSTACLE_EN (out-of-grid pixels read as obstacle).
module hpp_grid_fetcher
   import hpp_pkg::*;
(
   input  logic                 clock,
   input  logic                 reset,
   input  logic [9:0]           next_x,
   input  logic [9:0]           next_y,
   input  logic                 frame_start,
   output logic [CELL_BITS-1:0] grid_info,
   output logic                 mem_req,
   output logic [ADDR_W-1:0]    mem_addr,
   input  logic                 mem_gnt,
   input  logic [CELL_BITS-1:0] mem_rdata,
   output logic                 underrun
);

   localparam logic [9:0]        GRID_W_10  = 10'(GRID_W);
   localparam logic [9:0]        GRID_H_10  = 10'(GRID_H);
   localparam logic [ADDR_W-1:0] ROW_STRIDE = ADDR_W'(GRID_W);
   localparam logic [COL_W-1:0]  LAST_COL   = COL_W'(GRID_W - 1);

   fetch_state_e         state_q, state_d;
   logic [1:0]           valid_q, valid_d;
   logic [ROW_W-1:0]     disp_row_q, disp_row_d;
   logic                 disp_sel_q, disp_sel_d;
   logic                 underrun_q, underrun_d;
   logic                 mem_req_q, mem_req_d;
   logic                 tgt_bank_q, tgt_bank_d;
   logic                 rd_vld_q, rd_vld_d;
   logic [ADDR_W-1:0]    mem_addr_q, mem_addr_d;
   logic [ADDR_W-1:0]    base_q, base_d;
   logic [COL_W-1:0]     col_q, col_d;
   logic [COL_W-1:0]     col_d1_q, col_d1_d;

   logic [9:0]           cur_row, cur_col, disp_row_p1;
   logic                 next_row_hit, swap, abort, start_fill, oob, rd_bank;
   logic [CELL_BITS-1:0] rd_data;

   assign cur_row      = next_y >> CELL_SHIFT;
   assign cur_col      = next_x >> CELL_SHIFT;
   assign disp_row_p1  = 10'(disp_row_q) + 10'd1;
   assign next_row_hit = (cur_row == disp_row_p1);
   assign swap         = next_row_hit && (disp_row_p1 < GRID_H_10);
   assign rd_bank      = next_row_hit ? ~disp_sel_q : disp_sel_q;
   assign oob          = (cur_col >= GRID_W_10) || (cur_row >= GRID_H_10);

   hpp_line_buffer u_line_buffer (
      .clock   (clock),
      .reset   (reset),
      .wr_en   (rd_vld_q),
      .wr_bank (tgt_bank_q),
      .wr_col  (col_d1_q),
      .wr_data (mem_rdata),
      .rd_bank (rd_bank),
      .rd_col  (cur_col[COL_W-1:0]),
      .rd_data (rd_data)
   );

   // Pixel lookup: out-of-grid pixels get a fixed code, in-grid read the selected bank.
   always_comb begin
      grid_info = rd_data;
      if (oob) begin
`ifdef HPP_FETCH_OOB_OBSTACLE_EN
         grid_info = CELL_BITS'(1) << OBSTACLE_BIT;
`else
         grid_info = '0;
`endif
      end
   end

   // Next-state: frame restart, raster-driven bank swap, then the fetch engine.
   always_comb begin
      state_d    = state_q;
      valid_d    = valid_q;
      disp_row_d = disp_row_q;
      disp_sel_d = disp_sel_q;
      underrun_d = underrun_q;
      mem_req_d  = mem_req_q;
      tgt_bank_d = tgt_bank_q;
      mem_addr_d = mem_addr_q;
      base_d     = base_q;
      col_d      = col_q;
      col_d1_d   = col_d1_q;
      rd_vld_d   = 1'b0;
      abort      = 1'b0;
      start_fill = 1'b0;

      if (frame_start) begin
         valid_d    = 2'b00;
         disp_row_d = '0;
         disp_sel_d = 1'b0;
         underrun_d = 1'b0;
         base_d     = '0;
         state_d    = IDLE;
         mem_req_d  = 1'b0;
      end else begin
         if (swap) begin
            disp_row_d          = disp_row_q + ROW_W'(1);
            disp_sel_d          = ~disp_sel_q;
            base_d              = base_q + ROW_STRIDE;
            valid_d[disp_sel_q] = 1'b0;
            if (!valid_q[~disp_sel_q]) begin
               underrun_d = 1'b1;
            end
            // The bank being retired is the one under fill: its data is stale.
            if ((state_q != IDLE) && (tgt_bank_q == disp_sel_q)) begin
               abort = 1'b1;
            end
         end

         if (abort) begin
            state_d   = IDLE;
            mem_req_d = 1'b0;
         end else begin
            unique case (state_q)
               IDLE: begin
                  // Decide only on a quiet edge so the target reflects post-swap state.
                  if (!swap) begin
                     if (!valid_q[disp_sel_q]) begin
                        tgt_bank_d = disp_sel_q;
                        mem_addr_d = base_q;
                        start_fill = 1'b1;
                     end else if (!valid_q[~disp_sel_q] && (disp_row_p1 < GRID_H_10)) begin
                        tgt_bank_d = ~disp_sel_q;
                        mem_addr_d = base_q + ROW_STRIDE;
                        start_fill = 1'b1;
                     end
                  end
                  if (start_fill) begin
                     col_d     = '0;
                     mem_req_d = 1'b1;
                     state_d   = FILL;
                  end
               end
               FILL: begin
                  if (mem_gnt) begin
                     rd_vld_d = 1'b1;
                     col_d1_d = col_q;
                     if (col_q == LAST_COL) begin
                        mem_req_d = 1'b0;
                        state_d   = DRAIN;
                     end else begin
                        col_d      = col_q + COL_W'(1);
                        mem_addr_d = mem_addr_q + ADDR_W'(1);
                     end
                  end
               end
               DRAIN: begin
                  valid_d[tgt_bank_q] = 1'b1;
                  state_d             = IDLE;
               end
               default: begin
                  state_d   = IDLE;
                  mem_req_d = 1'b0;
               end
            endcase
         end
      end
   end

   // State registers.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q    <= IDLE;
         valid_q    <= 2'b00;
         disp_row_q <= '0;
         disp_sel_q <= 1'b0;
         underrun_q <= 1'b0;
         mem_req_q  <= 1'b0;
         tgt_bank_q <= 1'b0;
         rd_vld_q   <= 1'b0;
         mem_addr_q <= '0;
         base_q     <= '0;
         col_q      <= '0;
         col_d1_q   <= '0;
      end else begin
         state_q    <= state_d;
         valid_q    <= valid_d;
         disp_row_q <= disp_row_d;
         disp_sel_q <= disp_sel_d;
         underrun_q <= underrun_d;
         mem_req_q  <= mem_req_d;
         tgt_bank_q <= tgt_bank_d;
         rd_vld_q   <= rd_vld_d;
         mem_addr_q <= mem_addr_d;
         base_q     <= base_d;
         col_q      <= col_d;
         col_d1_q   <= col_d1_d;
      end
   end

   assign mem_req  = mem_req_q;
   assign mem_addr = mem_addr_q;
   assign underrun = underrun_q;

endmodule

// File: tb/tb_hpp_grid_fetcher.sv
// Directed-random bench for hpp_grid_fetcher: a grid RAM model with a grant
// input, a log of accepted addresses, and expected pixel data taken straight
// from the RAM image using the cell mapping.
module tb_hpp_grid_fetcher;

   localparam int GW = 80;

`ifdef HPP_FETCH_OOB_OBSTACLE_EN
   localparam int OOB_EXP = 16;
`else
   localparam int OOB_EXP = 0;
`endif

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic [9:0]  next_x = '0;
   logic [9:0]  next_y = '0;
   logic        frame_start = 1'b0;
   logic [4:0]  grid_info;
   logic        mem_req;
   logic [12:0] mem_addr;
   logic        mem_gnt = 1'b0;
   logic [4:0]  mem_rdata = '0;
   logic        underrun;

   int          tests = 0;
   int          fails = 0;
   logic [4:0]  ram [8192];
   int          acc_q [$];
   logic [9:0]  hold_y = '0;

   hpp_grid_fetcher dut (
      .clock       (clock),
      .reset       (reset),
      .next_x      (next_x),
      .next_y      (next_y),
      .frame_start (frame_start),
      .grid_info   (grid_info),
      .mem_req     (mem_req),
      .mem_addr    (mem_addr),
      .mem_gnt     (mem_gnt),
      .mem_rdata   (mem_rdata),
      .underrun    (underrun)
   );

   always #5 clock = ~clock;

   // Synchronous RAM, one-cycle read latency.
   always @(posedge clock) mem_rdata <= ram[mem_addr];

   // Record every accepted request address in order.
   always @(posedge clock) begin
      if (reset && mem_req && mem_gnt) acc_q.push_back(int'(mem_addr));
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic int ref_cell(input int x, input int y);
      return int'(ram[(y >> 3) * GW + (x >> 3)]);
   endfunction

   // Call right after a falling edge: look up a pixel, then restore the raster row.
   task automatic probe(input string tag, input int x, input int y, input int exp);
      next_x = 10'(x);
      next_y = 10'(y);
      #1;
      chk(tag, 32'(grid_info), 32'(exp));
      next_y = hold_y;
   endtask

   task automatic wait_acc(input int n, input int bound);
      int k = 0;
      while (acc_q.size() < n && k < bound) begin
         @(posedge clock);
         k++;
      end
      chk("accept_count", 32'(acc_q.size()), 32'(n));
      repeat (3) @(posedge clock);
   endtask

   task automatic check_seq(input string tag, input int base, input int n);
      int nbad = 0;
      chk({tag, "_len"}, 32'(acc_q.size()), 32'(n));
      for (int i = 0; i < n && i < acc_q.size(); i++) begin
         if (acc_q[i] != base + i) nbad++;
      end
      chk({tag, "_order"}, 32'(nbad), 32'd0);
   endtask

   task automatic wait_addr(input int target, input int bound);
      int k = 0;
      while (!(mem_req && int'(mem_addr) == target) && k < bound) begin
         @(negedge clock);
         k++;
      end
      chk("addr_reach", 32'(mem_addr), 32'(target));
   endtask

   initial begin
      for (int a = 0; a < 8192; a++) ram[a] = 5'($urandom);
      ram[2] = 5'd21;

      // Reset values
      #1;
      chk("rst_mem_req", 32'(mem_req), 32'd0);
      chk("rst_mem_addr", 32'(mem_addr), 32'd0);
      chk("rst_underrun", 32'(underrun), 32'd0);
      chk("rst_grid_info", 32'(grid_info), 32'd0);

      // Frame fill of rows 0 and 1 with continuous grant
      frame_start = 1'b1;
      mem_gnt = 1'b1;
      @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      frame_start = 1'b0;
      acc_q.delete();
      wait_acc(160, 400);
      check_seq("fill_seq", 0, 160);
      @(negedge clock);
      probe("probe_x17", 17, 0, int'(ram[2]));
      for (int i = 0; i < 8; i++) begin
         int x, y;
         x = int'($urandom_range(0, 639));
         y = int'($urandom_range(0, 15));
         @(negedge clock);
         probe("probe_r01", x, y, ref_cell(x, y));
      end

      // Swap on the 7 -> 8 row step, then prefetch of row 2
      @(negedge clock);
      next_x = '0;
      next_y = 10'd7;
      hold_y = 10'd7;
      #1;
      chk("row7", 32'(grid_info), 32'(ram[0]));
      @(negedge clock);
      acc_q.delete();
      next_y = 10'd8;
      hold_y = 10'd8;
      #1;
      chk("swap_same_cycle", 32'(grid_info), 32'(ram[80]));
      wait_acc(80, 300);
      check_seq("swap_fill", 160, 80);
      for (int i = 0; i < 6; i++) begin
         int x, y;
         x = int'($urandom_range(0, 639));
         y = int'($urandom_range(8, 23));
         @(negedge clock);
         probe("probe_r12", x, y, ref_cell(x, y));
      end

      // Grant stall at address 40
      @(negedge clock);
      hold_y = '0;
      next_y = '0;
      frame_start = 1'b1;
      @(negedge clock);
      frame_start = 1'b0;
      acc_q.delete();
      wait_addr(40, 100);
      mem_gnt = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clock);
         chk("stall_hold", 32'(mem_addr), 32'd40);
      end
      chk("stall_req", 32'(mem_req), 32'd1);
      mem_gnt = 1'b1;
      wait_acc(160, 400);
      check_seq("stall_seq", 0, 160);
      for (int c = 0; c < GW; c++) begin
         @(negedge clock);
         probe("row0_cell", c * 8 + 3, 5, int'(ram[c]));
      end
      for (int c = 0; c < GW; c++) begin
         @(negedge clock);
         probe("row1_cell", c * 8 + 6, 12, int'(ram[GW + c]));
      end

      // Underrun: grant withheld while the raster walks into row 2
      @(negedge clock);
      mem_gnt = 1'b0;
      next_y = 10'd8;
      hold_y = 10'd8;
      @(negedge clock);
      chk("no_underrun", 32'(underrun), 32'd0);
      next_y = 10'd16;
      hold_y = 10'd16;
      @(negedge clock);
      chk("underrun_set", 32'(underrun), 32'd1);
      repeat (20) @(negedge clock);
      chk("underrun_sticky", 32'(underrun), 32'd1);
      next_y = '0;
      hold_y = '0;
      frame_start = 1'b1;
      @(negedge clock);
      frame_start = 1'b0;
      chk("underrun_clr", 32'(underrun), 32'd0);

      // Out-of-grid lookups
      @(negedge clock);
      probe("oob_x", 700, 0, OOB_EXP);
      @(negedge clock);
      probe("oob_y", 5, 500, OOB_EXP);

      // Asynchronous reset in the middle of a fill
      mem_gnt = 1'b1;
      wait_addr(20, 100);
      @(posedge clock);
      #2;
      reset = 1'b0;
      next_x = 10'd17;
      next_y = '0;
      #1;
      chk("arst_mem_req", 32'(mem_req), 32'd0);
      chk("arst_mem_addr", 32'(mem_addr), 32'd0);
      chk("arst_underrun", 32'(underrun), 32'd0);
      chk("arst_grid_info", 32'(grid_info), 32'd0);
      @(negedge clock);
      reset = 1'b1;
      repeat (3) @(negedge clock);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
